// File: rtl/forwardk_nlink.sv
// forwardk_nlink: planar forward kinematics for an N-link arm in signed fixed point
// Q(BIT_WIDTH-FRACTIONS).FRACTIONS. One shared cos/sin table pair and one multiplier
// pair are reused for every link (ANGLE -> TRIG -> MAC per link).
// Build option: define FORWARDK_SAT_EN to clamp overflowing products/sums to the
// signed extremes. Without it, results wrap. ovf_o is raised in both builds.
// The trig table assumes BIT_WIDTH >= 17. Angles are in radians.
module forwardk_nlink #(
    parameter int BIT_WIDTH = 32,
    parameter int FRACTIONS = 15,
    parameter int NUM_LINKS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_LINKS*BIT_WIDTH-1:0] theta_i,
    input  logic [NUM_LINKS*BIT_WIDTH-1:0] len_i,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [BIT_WIDTH-1:0]           x_o,
    output logic [BIT_WIDTH-1:0]           y_o,
    output logic                           ovf_o
);
    localparam int KW = $clog2(NUM_LINKS + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ANGLE = 3'd1;
    localparam logic [2:0] S_TRIG  = 3'd2;
    localparam logic [2:0] S_MAC   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Radians (Q.FRACTIONS) to a 32-bit phase where 2^32 is one full turn.
    localparam logic [31:0] PHASE_K =
        32'($rtoi((2.0 ** (32 - FRACTIONS)) / 6.283185307179586 + 0.5));
    // The table is stored in Q.15; rescale to the configured fraction width.
    localparam int SHL = (FRACTIONS >= 15) ? FRACTIONS - 15 : 0;
    localparam int SHR = (FRACTIONS < 15) ? 15 - FRACTIONS : 0;

`ifdef FORWARDK_SAT_EN
    localparam logic [BIT_WIDTH-1:0] SAT_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic [BIT_WIDTH-1:0] SAT_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};
`endif

    // Quarter-wave sine, 64 steps over [0, pi/2], Q.15, last entry is exactly 1.0.
    localparam logic [15:0] QSIN [0:64] = '{
        16'd0,     16'd804,   16'd1608,  16'd2411,  16'd3212,  16'd4011,  16'd4808,  16'd5602,
        16'd6393,  16'd7180,  16'd7962,  16'd8740,  16'd9512,  16'd10279, 16'd11039, 16'd11793,
        16'd12540, 16'd13279, 16'd14010, 16'd14733, 16'd15447, 16'd16151, 16'd16846, 16'd17531,
        16'd18205, 16'd18868, 16'd19520, 16'd20160, 16'd20788, 16'd21403, 16'd22006, 16'd22595,
        16'd23170, 16'd23732, 16'd24279, 16'd24812, 16'd25330, 16'd25832, 16'd26319, 16'd26791,
        16'd27246, 16'd27684, 16'd28106, 16'd28511, 16'd28899, 16'd29269, 16'd29622, 16'd29957,
        16'd30274, 16'd30572, 16'd30853, 16'd31114, 16'd31357, 16'd31581, 16'd31786, 16'd31972,
        16'd32138, 16'd32286, 16'd32413, 16'd32522, 16'd32610, 16'd32679, 16'd32729, 16'd32758,
        16'd32768
    };

    // Reduce a signed double-width product to BIT_WIDTH; MSB of result is the overflow flag.
    function automatic logic [BIT_WIDTH:0] narrow(input logic signed [2*BIT_WIDTH-1:0] v);
        logic fits;
        fits = (&v[2*BIT_WIDTH-1:BIT_WIDTH-1]) | ~(|v[2*BIT_WIDTH-1:BIT_WIDTH-1]);
        if (fits) return {1'b0, v[BIT_WIDTH-1:0]};
`ifdef FORWARDK_SAT_EN
        return {1'b1, v[2*BIT_WIDTH-1] ? SAT_MIN : SAT_MAX};
`else
        return {1'b1, v[BIT_WIDTH-1:0]};
`endif
    endfunction

    // Signed add with overflow flag in the MSB of the result.
    function automatic logic [BIT_WIDTH:0] acc_add(input logic [BIT_WIDTH-1:0] a,
                                                   input logic [BIT_WIDTH-1:0] b);
        logic [BIT_WIDTH:0] s;
        s = {a[BIT_WIDTH-1], a} + {b[BIT_WIDTH-1], b};
        if (s[BIT_WIDTH] == s[BIT_WIDTH-1]) return {1'b0, s[BIT_WIDTH-1:0]};
`ifdef FORWARDK_SAT_EN
        return {1'b1, s[BIT_WIDTH] ? SAT_MIN : SAT_MAX};
`else
        return {1'b1, s[BIT_WIDTH-1:0]};
`endif
    endfunction

    logic [2:0]                  state_reg;
    logic [KW-1:0]               k_reg;
    logic signed [BIT_WIDTH-1:0] theta_reg [NUM_LINKS];
    logic signed [BIT_WIDTH-1:0] len_reg   [NUM_LINKS];
    logic signed [BIT_WIDTH-1:0] theta_in  [NUM_LINKS];
    logic signed [BIT_WIDTH-1:0] len_in    [NUM_LINKS];
    logic signed [BIT_WIDTH-1:0] theta_acc_reg, cos_reg, sin_reg;
    logic [BIT_WIDTH-1:0]        x_acc_reg, y_acc_reg;
    logic                        ovf_reg;

    for (genvar gi = 0; gi < NUM_LINKS; gi++) begin : g_unpack
        assign theta_in[gi] = theta_i[gi*BIT_WIDTH +: BIT_WIDTH];
        assign len_in[gi]   = len_i[gi*BIT_WIDTH +: BIT_WIDTH];
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = (state_reg == S_DONE);

    // Select the current link's angle and length.
    logic signed [BIT_WIDTH-1:0] theta_cur, len_cur;
    always_comb begin
        theta_cur = '0;
        len_cur   = '0;
        for (int i = 0; i < NUM_LINKS; i++) begin
            if (k_reg == KW'(i)) begin
                theta_cur = theta_reg[i];
                len_cur   = len_reg[i];
            end
        end
    end

    // Combinational cos/sin table: phase quadrant folding over the quarter-wave sine.
    logic [31:0]                 phase;
    logic [8:0]                  phase_top;
    logic [1:0]                  quad;
    logic [6:0]                  r_idx;
    logic [15:0]                 sin_mag, cos_mag;
    logic signed [BIT_WIDTH-1:0] sin_s, cos_s, sin_lut, cos_lut;
    always_comb begin
        phase     = 32'(theta_acc_reg) * PHASE_K;
        phase_top = 9'(phase >> 23);
        quad      = phase_top[8:7];
        r_idx     = {1'b0, phase_top[6:1]} + 7'(phase_top[0]);
        sin_mag   = quad[0] ? QSIN[7'd64 - r_idx] : QSIN[r_idx];
        cos_mag   = quad[0] ? QSIN[r_idx] : QSIN[7'd64 - r_idx];
        sin_s     = (BIT_WIDTH'(sin_mag) <<< SHL) >>> SHR;
        cos_s     = (BIT_WIDTH'(cos_mag) <<< SHL) >>> SHR;
        sin_lut   = quad[1] ? -sin_s : sin_s;
        cos_lut   = (quad[1] ^ quad[0]) ? -cos_s : cos_s;
    end

    // Shared multiply-accumulate for the current link.
    logic signed [2*BIT_WIDTH-1:0] prod_x, prod_y;
    logic [BIT_WIDTH:0]            nx, ny, sx, sy;
    logic                          mac_ovf;
    always_comb begin
        prod_x  = (2*BIT_WIDTH)'(len_cur) * (2*BIT_WIDTH)'(cos_reg);
        prod_y  = (2*BIT_WIDTH)'(len_cur) * (2*BIT_WIDTH)'(sin_reg);
        nx      = narrow(prod_x >>> FRACTIONS);
        ny      = narrow(prod_y >>> FRACTIONS);
        sx      = acc_add(x_acc_reg, nx[BIT_WIDTH-1:0]);
        sy      = acc_add(y_acc_reg, ny[BIT_WIDTH-1:0]);
        mac_ovf = nx[BIT_WIDTH] | ny[BIT_WIDTH] | sx[BIT_WIDTH] | sy[BIT_WIDTH];
    end

    // Control FSM and datapath registers; reset discards any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            k_reg         <= '0;
            theta_acc_reg <= '0;
            cos_reg       <= '0;
            sin_reg       <= '0;
            x_acc_reg     <= '0;
            y_acc_reg     <= '0;
            ovf_reg       <= 1'b0;
            x_o           <= '0;
            y_o           <= '0;
            ovf_o         <= 1'b0;
            for (int i = 0; i < NUM_LINKS; i++) begin
                theta_reg[i] <= '0;
                len_reg[i]   <= '0;
            end
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NUM_LINKS; i++) begin
                            theta_reg[i] <= theta_in[i];
                            len_reg[i]   <= len_in[i];
                        end
                        theta_acc_reg <= '0;
                        x_acc_reg     <= '0;
                        y_acc_reg     <= '0;
                        ovf_reg       <= 1'b0;
                        k_reg         <= '0;
                        state_reg     <= S_ANGLE;
                    end
                end
                S_ANGLE: begin
                    theta_acc_reg <= theta_acc_reg + theta_cur;
                    state_reg     <= S_TRIG;
                end
                S_TRIG: begin
                    cos_reg   <= cos_lut;
                    sin_reg   <= sin_lut;
                    state_reg <= S_MAC;
                end
                S_MAC: begin
                    x_acc_reg <= sx[BIT_WIDTH-1:0];
                    y_acc_reg <= sy[BIT_WIDTH-1:0];
                    ovf_reg   <= ovf_reg | mac_ovf;
                    k_reg     <= k_reg + 1'b1;
                    if (k_reg == KW'(NUM_LINKS - 1)) begin
                        x_o       <= sx[BIT_WIDTH-1:0];
                        y_o       <= sy[BIT_WIDTH-1:0];
                        ovf_o     <= ovf_reg | mac_ovf;
                        state_reg <= S_DONE;
                    end else begin
                        state_reg <= S_ANGLE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_forwardk_nlink.sv
// tb_forwardk_nlink: directed vectors for a 2-link forwardk_nlink; expected results are
// queued when a request is issued and a monitor checks them at each output handshake.
module tb_forwardk_nlink;
    localparam int W = 32;
    localparam int N = 2;

    localparam logic [31:0] PI2  = 32'd51472;   // pi/2 in Q.15
    localparam logic [31:0] PI   = 32'd102944;  // pi in Q.15
    localparam logic [31:0] HALF = 32'h0000_4000;
    localparam logic [31:0] ONE  = 32'h0000_8000;
    localparam logic [31:0] LMAX = 32'h7FFF_FFFF;
`ifdef FORWARDK_SAT_EN
    localparam logic [31:0] T4_X = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] T4_X = 32'hFFFF_FFFE;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, ovf_o;
    logic [N*W-1:0] theta_i = '0;
    logic [N*W-1:0] len_i = '0;
    logic [W-1:0] x_o, y_o;

    forwardk_nlink #(.BIT_WIDTH(W), .FRACTIONS(15), .NUM_LINKS(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .theta_i(theta_i), .len_i(len_i), .out_valid(out_valid), .out_ready(out_ready),
        .x_o(x_o), .y_o(y_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        ovf;
        int          tx;
        int          ty;
        int          id;
    } exp_t;
    exp_t sb[$];
    int next_id = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    task automatic chk_tol(input string nm, input logic [31:0] act, input logic [31:0] exp_v,
                           input int tol);
        int d;
        d = int'(act - exp_v);
        n_cmp++;
        if ($isunknown(act) || d > tol || d < -tol) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h +/- %0d", nm, act, exp_v, tol);
        end
    endtask

    // Present a request, optionally queue its expected result, wait for acceptance.
    task automatic issue(input logic [31:0] t0, input logic [31:0] t1,
                         input logic [31:0] l0, input logic [31:0] l1,
                         input logic [31:0] ex, input logic [31:0] ey, input logic eovf,
                         input int tx, input int ty, input bit push, output int acc_cyc);
        if (push) begin
            sb.push_back('{ex, ey, eovf, tx, ty, next_id});
            next_id++;
        end
        theta_i  = {t1, t0};
        len_i    = {l1, l0};
        in_valid = 1'b1;
        acc_cyc  = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc;
                break;
            end
        end
        if (acc_cyc < 0) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int c);
        c = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_req();
        int c;
        wait_out(c);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare whenever a result is handed over.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("result %0d: x=%h y=%h ovf=%b", e.id, x_o, y_o, ovf_o);
                chk_tol($sformatf("res%0d_x", e.id), x_o, e.x, e.tx);
                chk_tol($sformatf("res%0d_y", e.id), y_o, e.y, e.ty);
                chk($sformatf("res%0d_ovf", e.id), 32'(ovf_o), 32'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, a0, a1, a2;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_x", x_o, 32'd0);
        chk("rst_y", y_o, 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Straight arm: latency from accept to out_valid
        issue(32'd0, 32'd0, HALF, HALF, ONE, 32'd0, 1'b0, 0, 0, 1'b1, a);
        in_valid = 1'b0;
        wait_out(b);
        chk("t1_latency", 32'(b - a), 32'd7);
        @(posedge clk);
        #1;

        // Base joint at pi/2
        issue(PI2, 32'd0, HALF, HALF, 32'd0, ONE, 1'b0, 1, 2, 1'b1, a);
        in_valid = 1'b0;
        finish_req();

        // Cumulative angles with distinct lengths: link0 at pi/2, link1 at pi
        issue(PI2, PI2, ONE, HALF, 32'hFFFF_C000, ONE, 1'b0, 0, 0, 1'b1, a);
        in_valid = 1'b0;
        finish_req();

        // Pointing backwards: negative x
        issue(PI, 32'd0, HALF, HALF, 32'hFFFF_8000, 32'd0, 1'b0, 0, 0, 1'b1, a);
        in_valid = 1'b0;
        finish_req();

        // Back-pressure in DONE: outputs held, new requests ignored
        out_ready = 1'b0;
        issue(32'd0, 32'd0, HALF, HALF, ONE, 32'd0, 1'b0, 0, 0, 1'b1, a);
        in_valid = 1'b0;
        wait_out(b);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            theta_i  = {32'd0, PI};
            @(negedge clk);
            chk($sformatf("hold%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("hold%0d_x", i), x_o, ONE);
            chk($sformatf("hold%0d_y", i), y_o, 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_x_kept", x_o, ONE);
        @(posedge clk);
        #1;

        // Overflow on the x accumulation
        issue(32'd0, 32'd0, LMAX, LMAX, T4_X, 32'd0, 1'b1, 0, 0, 1'b1, a);
        in_valid = 1'b0;
        finish_req();

        // Asynchronous reset during the MAC step of link 0
        issue(32'd0, 32'd0, HALF, HALF, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0, a);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_x", x_o, 32'd0);
        chk("arst_y", y_o, 32'd0);
        chk("arst_ovf", 32'(ovf_o), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        issue(32'd0, 32'd0, HALF, HALF, ONE, 32'd0, 1'b0, 0, 0, 1'b1, a);
        in_valid = 1'b0;
        finish_req();

        // Back-to-back requests with in_valid and out_ready held high
        out_ready = 1'b1;
        issue(32'd0, 32'd0, LMAX, LMAX, T4_X, 32'd0, 1'b1, 0, 0, 1'b1, a0);
        issue(32'd0, 32'd0, HALF, HALF, ONE, 32'd0, 1'b0, 0, 0, 1'b1, a1);
        issue(PI, 32'd0, HALF, HALF, 32'hFFFF_8000, 32'd0, 1'b0, 0, 0, 1'b1, a2);
        in_valid = 1'b0;
        chk("b2b_spacing_1", 32'(a1 - a0), 32'd8);
        chk("b2b_spacing_2", 32'(a2 - a1), 32'd8);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
